// File: rtl/ql_pkg.sv
// Shared QL IPC link definitions: link state encoding, timer sizing and default timeout.
// Latency: none; no backpressure.
package ql_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_SHIFT = 2'd2
  } ql_state_e;

  localparam int          QL_TIMER_W         = 20;
  localparam logic [19:0] QL_TIMEOUT_DEFAULT = 20'd550000;

  // Frame bits leave LSB first; vacated positions fill with 0.
  function automatic logic [3:0] ql_shift(input logic [3:0] v);
    return {1'b0, v[3:1]};
  endfunction

endpackage

// File: rtl/ql_sync.sv
// Multi-flop synchronizer for one asynchronous bit, with a selectable reset level.
// Latency: STAGES clk; no backpressure.
module ql_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ff_q <= {STAGES{RST_VAL}};
    end else begin
      ff_q <= (ff_q << 1) | STAGES'(d);
    end
  end

  assign q = ff_q[STAGES-1];

endmodule

// File: rtl/ipc_link_ctrl.sv
// IPC comdata link: CPU loads a 4-bit frame, one bit leaves per synchronized comctrl falling edge.
// Latency: SYNC_STAGES+1 clk from comctrl edge to output; no backpressure, CPU polls busy.
module ipc_link_ctrl
  import ql_pkg::*;
#(
  parameter logic [19:0] TIMEOUT_CYCLES = QL_TIMEOUT_DEFAULT,
  parameter int          SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cen,
  input  logic       wr_stb,
  input  logic [3:0] wr_data,
  input  logic       err_clr,
  input  logic       comctrl,
  input  logic       comdata_ipc,
  output logic       comdata_out,
  output logic       comdata_status,
  output logic       busy,
  output logic       rx_bit,
  output logic       timeout_err
);

  ql_state_e             state_q, state_d;
  logic [3:0]            shreg_q, shreg_d;
  logic [QL_TIMER_W-1:0] timer_q, timer_d;
  logic                  rx_bit_q, rx_bit_d;
  logic                  err_q, err_d;
  logic                  ctrl_prev_q;
  logic                  ctrl_sync, data_sync;
  logic                  fall, load, clr, expired;

  // comctrl idles high so its chain resets to 1, avoiding a false edge at reset release.
  ql_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ctrl (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (comctrl),
    .q       (ctrl_sync)
  );

  ql_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_data (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (comdata_ipc),
    .q       (data_sync)
  );

  assign fall    = ctrl_prev_q & ~ctrl_sync;
  assign load    = wr_stb & cen;
  assign clr     = err_clr & cen;
  assign expired = (state_q != ST_IDLE) && (timer_q == (TIMEOUT_CYCLES - 20'd1));

  // Priority: CPU load, then comctrl edge, then timeout; the edge restarts the timer.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    timer_d  = timer_q;
    err_d    = err_q;
    rx_bit_d = rx_bit_q;

    if (fall) begin
      rx_bit_d = data_sync;
    end
    if (clr) begin
      err_d = 1'b0;
    end

    if (load) begin
      shreg_d = wr_data;
      timer_d = '0;
      state_d = ST_ARMED;
    end else if (fall) begin
      shreg_d = ql_shift(shreg_q);
      timer_d = '0;
      case (state_q)
        ST_ARMED: state_d = ST_SHIFT;
        ST_SHIFT: state_d = ST_IDLE;
        default:  state_d = state_q;
      endcase
    end else if (expired) begin
      shreg_d = '0;
      timer_d = '0;
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end else if (state_q != ST_IDLE) begin
      timer_d = timer_q + QL_TIMER_W'(1);
    end else begin
      timer_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      timer_q     <= '0;
      rx_bit_q    <= 1'b0;
      err_q       <= 1'b0;
      ctrl_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      timer_q     <= timer_d;
      rx_bit_q    <= rx_bit_d;
      err_q       <= err_d;
      ctrl_prev_q <= ctrl_sync;
    end
  end

  assign comdata_out    = shreg_q[0];
  assign comdata_status = shreg_q[0] & data_sync;
  assign busy           = (state_q != ST_IDLE);
  assign rx_bit         = rx_bit_q;
  assign timeout_err    = err_q;

endmodule

// File: tb/tb_ipc_link_ctrl.sv
// Bench for ipc_link_ctrl: directed link scenarios plus random traffic against a frame-level model.
module tb_ipc_link_ctrl;

  localparam int S = 2;
  localparam int T = 100;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cen, wr_stb, err_clr, comctrl, comdata_ipc;
  logic [3:0] wr_data;
  logic       comdata_out, comdata_status, busy, rx_bit, timeout_err;

  ipc_link_ctrl #(.TIMEOUT_CYCLES(20'd100), .SYNC_STAGES(S)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cen            (cen),
    .wr_stb         (wr_stb),
    .wr_data        (wr_data),
    .err_clr        (err_clr),
    .comctrl        (comctrl),
    .comdata_ipc    (comdata_ipc),
    .comdata_out    (comdata_out),
    .comdata_status (comdata_status),
    .busy           (busy),
    .rx_bit         (rx_bit),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [4:0] exp_q[$];

  // Reference model: input history lines stand in for the synchronizers; the frame is
  // a word plus the number of comctrl edges still owed, aged in clock edges.
  bit          ch[$];
  bit          dh[$];
  int unsigned m_word, m_pend, m_age;
  bit          m_rx, m_err;
  bit          cur_c, cur_d;

  function automatic void model_reset();
    ch.delete();
    dh.delete();
    for (int i = 0; i < 8; i++) begin
      ch.push_back(1'b1);
      dh.push_back(1'b0);
    end
    m_word = 0; m_pend = 0; m_age = 0; m_rx = 1'b0; m_err = 1'b0;
  endfunction

  function automatic logic [4:0] model_step(bit load, bit [3:0] wd, bit clr, bit cc, bit dd);
    int n;
    bit fall;
    ch.push_back(cc);
    dh.push_back(dd);
    void'(ch.pop_front());
    void'(dh.pop_front());
    n    = ch.size();
    fall = ch[n-2-S] && !ch[n-1-S];
    if (fall) m_rx = dh[n-1-S];
    if (clr) m_err = 1'b0;
    if (load) begin
      m_word = wd; m_pend = 2; m_age = 0;
    end else if (fall) begin
      m_word = m_word / 2;
      if (m_pend > 0) m_pend--;
      m_age = 0;
    end else if (m_pend > 0) begin
      m_age++;
      if (m_age == T) begin
        m_word = 0; m_pend = 0; m_age = 0; m_err = 1'b1;
      end
    end
    return {m_word[0], m_word[0] & dh[n-S], m_pend != 0, m_rx, m_err};
  endfunction

  task automatic cyc(input bit w, input bit [3:0] wd, input bit c, input bit clr,
                     input bit cc, input bit dd);
    @(negedge clk);
    reset_n     = 1'b1;
    cen         = c;
    wr_stb      = w;
    wr_data     = wd;
    err_clr     = clr;
    comctrl     = cc;
    comdata_ipc = dd;
    exp_q.push_back(model_step(w & c, wd, clr & c, cc, dd));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 1'b1, 1'b0, cur_c, cur_d);
  endtask

  task automatic load(input bit [3:0] wd);
    cyc(1'b1, wd, 1'b1, 1'b0, cur_c, cur_d);
  endtask

  task automatic clear_err();
    cyc(1'b0, 4'd0, 1'b1, 1'b1, cur_c, cur_d);
  endtask

  task automatic check_zero(input string name);
    logic [4:0] a;
    a = {comdata_out, comdata_status, busy, rx_bit, timeout_err};
    vectors++;
    if (a !== 5'b00000) begin
      miscompares++;
      $display("FAIL %s t=%0t out/stat/busy/rx/err got %b required 00000", name, $time, a);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_zero("async_reset");
    model_reset();
    repeat (2) @(posedge clk);
  endtask

  // Monitor: every clock edge that had stimulus behind it has one expected snapshot queued.
  initial begin
    logic [4:0] e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {comdata_out, comdata_status, busy, rx_bit, timeout_err};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL link_outputs t=%0t out/stat/busy/rx/err got %b required %b", $time, a, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    miscompares++;
    $display("FAIL watchdog t=%0t stimulus did not complete", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit slow;
    reset_n = 1'b0; cen = 1'b0; wr_stb = 1'b0; wr_data = 4'd0; err_clr = 1'b0;
    comctrl = 1'b1; comdata_ipc = 1'b0;
    cur_c = 1'b1; cur_d = 1'b1;
    model_reset();
    #3;
    check_zero("reset_state");
    repeat (3) @(posedge clk);

    // Frame 1101 shifted by two comctrl falls: out 1,0,1 then idle.
    idle(4);
    load(4'b1101);
    idle(5);
    cur_c = 1'b0; idle(5);
    cur_c = 1'b1; idle(5);
    cur_c = 1'b0; idle(6);
    cur_c = 1'b1; idle(3);

    // IPC pulls comdata low while our bit is 1.
    load(4'b0101);
    idle(3);
    cur_d = 1'b0; idle(5);
    cur_c = 1'b0; idle(5);
    cur_c = 1'b1; cur_d = 1'b1; idle(4);
    cur_c = 1'b0; idle(5);
    cur_c = 1'b1; idle(3);

    // Timeout with no falls, then clear.
    load(4'b1111);
    idle(T + 5);
    clear_err();
    idle(3);

    // Load coincident with a synchronized fall: edge is discarded.
    cur_c = 1'b1; idle(4);
    cur_c = 1'b0;
    idle(2);
    load(4'b0110);
    idle(4);
    cur_c = 1'b1; idle(4);
    cur_c = 1'b0; idle(4);
    cur_c = 1'b1; idle(4);
    cur_c = 1'b0; idle(4);
    cur_c = 1'b1; idle(4);

    // Timeout and err_clr on the same edge: flag stays set.
    clear_err();
    load(4'b0011);
    idle(T - 1);
    clear_err();
    idle(3);

    // Timeout and load on the same edge: load wins, flag untouched.
    clear_err();
    load(4'b1001);
    idle(T - 1);
    load(4'b0111);
    idle(3);
    cur_c = 1'b0; idle(4);
    cur_c = 1'b1; idle(4);
    cur_c = 1'b0; idle(4);
    cur_c = 1'b1; idle(4);

    // Reset mid-frame after the first fall.
    load(4'b1011);
    idle(3);
    cur_c = 1'b0; idle(5);
    do_reset();
    idle(4);
    cur_c = 1'b1; idle(4);

    // Random traffic, alternating fast and slow comctrl to mix completions and timeouts.
    slow = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) slow = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, slow ? 199 : 7) == 0) cur_c = ~cur_c;
      if ($urandom_range(0, 5) == 0) cur_d = ~cur_d;
      cyc($urandom_range(0, 39) == 0, 4'($urandom), $urandom_range(0, 3) != 0,
          $urandom_range(0, 49) == 0, cur_c, cur_d);
      if (i == 2000) do_reset();
    end

    @(posedge clk);
    #2;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
